// File: rtl/core_if_pkg.sv
// Shared types and constants for the accelerator core word interface.
package core_if_pkg;

   localparam int WORD_W  = 16;
   localparam int FFT_LEN = 64;

   localparam logic [1:0] MODE_FFT = 2'b00;
   localparam logic [1:0] MODE_FIR = 2'b01;

   typedef enum logic [2:0] {
      RX_B0,
      RX_B1,
      SETUP,
      DRIVE_HI,
      DRIVE_LO
   } rx_state_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_REQ,
      TX_GAP,
      TX_B0,
      TX_B1
   } tx_state_e;

   // Build a word from two bytes in arrival order.
   function automatic logic [WORD_W-1:0] pack_word(input logic [7:0] first_b,
                                                   input logic [7:0] second_b,
                                                   input bit         lsb_first);
      return lsb_first ? {second_b, first_b} : {first_b, second_b};
   endfunction

   // Pick the high or low byte of a word.
   function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w,
                                            input bit                sel_hi);
      return sel_hi ? w[15:8] : w[7:0];
   endfunction

endpackage

// File: rtl/core_if_rise_det.sv
// Registered rising-edge detector; the pulse is combinational from the
// current input and the registered previous value.
module core_if_rise_det (
   input  logic clk,
   input  logic rstb,
   input  logic d_i,
   output logic pulse_o
);

   logic prev_q;

   // Remember last cycle's input level.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) prev_q <= 1'b0;
      else       prev_q <= d_i;
   end

   assign pulse_o = d_i & ~prev_q;

endmodule

// File: rtl/core_host_bridge.sv
// Host byte stream <-> accelerator core word interface bridge.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RX_B0    | waiting for first host byte
// RX_B1    | waiting for second host byte
// SETUP    | load assembled word onto core_data_in, strobe still low
// DRIVE_HI | core_data_in_valid high (registered, one cycle behind state)
// DRIVE_LO | core_data_in_valid low gap before accepting the next word
// TX_IDLE  | no request outstanding
// TX_REQ   | core_tx_done high, waiting for a data_out_valid rising edge
// TX_GAP   | one low cycle on core_tx_done so the core sees a fresh edge
// TX_B0    | first captured byte offered to host
// TX_B1    | second captured byte offered to host
module core_host_bridge
   import core_if_pkg::*;
#(
   parameter int VALID_HI_CYC = 2,
   parameter int VALID_LO_CYC = 2,
   parameter bit LSB_FIRST    = 1'b1,
   parameter int REQ_TIMEOUT  = 16
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic [7:0]        host_rx_byte,
   input  logic              host_rx_valid,
   output logic              host_rx_ready,
   output logic [7:0]        host_tx_byte,
   output logic              host_tx_valid,
   input  logic              host_tx_ready,
   output logic [WORD_W-1:0] core_data_in,
   output logic              core_data_in_valid,
   output logic              core_tx_done,
   input  logic [WORD_W-1:0] core_data_out,
   input  logic              core_data_out_valid,
   input  logic              core_busy,
   input  logic              pull_en,
   output logic              tx_err
);

   localparam int RX_MAX = (VALID_HI_CYC > VALID_LO_CYC) ? VALID_HI_CYC : VALID_LO_CYC;
   localparam int RX_CW  = $clog2(RX_MAX + 1);
   localparam int TX_CW  = $clog2(REQ_TIMEOUT + 1);

   localparam logic [RX_CW-1:0] HI_LOAD = RX_CW'(VALID_HI_CYC - 1);
   localparam logic [RX_CW-1:0] LO_LOAD = RX_CW'(VALID_LO_CYC - 1);
   localparam logic [TX_CW-1:0] TO_LOAD = TX_CW'(REQ_TIMEOUT - 1);

   rx_state_e          rx_state_q, rx_state_d;
   logic [RX_CW-1:0]   rx_cnt_q, rx_cnt_d;
   logic [7:0]         byte0_q, byte0_d, byte1_q, byte1_d;
   logic [WORD_W-1:0]  data_in_q, data_in_d;
   logic               valid_q, valid_d;

   tx_state_e          tx_state_q, tx_state_d;
   logic [TX_CW-1:0]   tx_cnt_q, tx_cnt_d;
   logic [WORD_W-1:0]  cap_q, cap_d;
   logic               err_q, err_d;
   logic               out_rise;

   core_if_rise_det u_rise (
      .clk     (clk),
      .rstb    (rstb),
      .d_i     (core_data_out_valid),
      .pulse_o (out_rise)
   );

   // Ingress next-state: byte assembly, setup, strobe high/low timing.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      byte0_d    = byte0_q;
      byte1_d    = byte1_q;
      data_in_d  = data_in_q;
      valid_d    = (rx_state_q == DRIVE_HI);
      case (rx_state_q)
         RX_B0: if (host_rx_valid) begin
            byte0_d    = host_rx_byte;
            rx_state_d = RX_B1;
         end
         RX_B1: if (host_rx_valid) begin
            byte1_d    = host_rx_byte;
            rx_state_d = SETUP;
         end
         SETUP: begin
            data_in_d  = pack_word(byte0_q, byte1_q, LSB_FIRST);
            rx_cnt_d   = HI_LOAD;
            rx_state_d = DRIVE_HI;
         end
         DRIVE_HI: if (rx_cnt_q == '0) begin
            rx_cnt_d   = LO_LOAD;
            rx_state_d = DRIVE_LO;
         end else begin
            rx_cnt_d = rx_cnt_q - 1'b1;
         end
         DRIVE_LO: if (rx_cnt_q == '0) rx_state_d = RX_B0;
                   else                rx_cnt_d   = rx_cnt_q - 1'b1;
         default: rx_state_d = RX_B0;
      endcase
   end

   // Ingress registers.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         rx_state_q <= RX_B0;
         rx_cnt_q   <= '0;
         byte0_q    <= '0;
         byte1_q    <= '0;
         data_in_q  <= '0;
         valid_q    <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         byte0_q    <= byte0_d;
         byte1_q    <= byte1_d;
         data_in_q  <= data_in_d;
         valid_q    <= valid_d;
      end
   end

   // Egress next-state: request with timeout re-pulse, capture, serialize.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      cap_d      = cap_q;
      err_d      = err_q | (out_rise && (tx_state_q != TX_REQ));
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = TO_LOAD;
            if (pull_en && !core_busy) tx_state_d = TX_REQ;
         end
         TX_REQ: begin
            // A capture wins over a same-cycle timeout or abort.
            if (out_rise) begin
               cap_d      = core_data_out;
               tx_state_d = TX_B0;
            end else if (!pull_en || core_busy) begin
               tx_state_d = TX_IDLE;
            end else if (tx_cnt_q == '0) begin
               tx_state_d = TX_GAP;
            end else begin
               tx_cnt_d = tx_cnt_q - 1'b1;
            end
         end
         TX_GAP: begin
            tx_cnt_d   = TO_LOAD;
            tx_state_d = (pull_en && !core_busy) ? TX_REQ : TX_IDLE;
         end
         TX_B0: if (host_tx_ready) tx_state_d = TX_B1;
         TX_B1: if (host_tx_ready) tx_state_d = TX_IDLE;
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // Egress registers.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         cap_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         cap_q      <= cap_d;
         err_q      <= err_d;
      end
   end

   // Ready is gated by rstb so it reads 0 for the whole reset interval.
   assign host_rx_ready      = rstb & ((rx_state_q == RX_B0) | (rx_state_q == RX_B1));
   assign core_data_in       = data_in_q;
   assign core_data_in_valid = valid_q;
   assign core_tx_done       = (tx_state_q == TX_REQ);
   assign host_tx_valid      = (tx_state_q == TX_B0) | (tx_state_q == TX_B1);
   assign host_tx_byte       = (tx_state_q == TX_B0) ? word_byte(cap_q, !LSB_FIRST) :
                               (tx_state_q == TX_B1) ? word_byte(cap_q,  LSB_FIRST) : 8'h00;
   assign tx_err             = err_q;

endmodule

// File: tb/tb_core_host_bridge.sv
// Directed bench for core_host_bridge with default parameters.
module tb_core_host_bridge;

   logic        clk;
   logic        rstb;
   logic [7:0]  host_rx_byte;
   logic        host_rx_valid;
   logic        host_rx_ready;
   logic [7:0]  host_tx_byte;
   logic        host_tx_valid;
   logic        host_tx_ready;
   logic [15:0] core_data_in;
   logic        core_data_in_valid;
   logic        core_tx_done;
   logic [15:0] core_data_out;
   logic        core_data_out_valid;
   logic        core_busy;
   logic        pull_en;
   logic        tx_err;

   core_host_bridge dut (
      .clk                 (clk),
      .rstb                (rstb),
      .host_rx_byte        (host_rx_byte),
      .host_rx_valid       (host_rx_valid),
      .host_rx_ready       (host_rx_ready),
      .host_tx_byte        (host_tx_byte),
      .host_tx_valid       (host_tx_valid),
      .host_tx_ready       (host_tx_ready),
      .core_data_in        (core_data_in),
      .core_data_in_valid  (core_data_in_valid),
      .core_tx_done        (core_tx_done),
      .core_data_out       (core_data_out),
      .core_data_out_valid (core_data_out_valid),
      .core_busy           (core_busy),
      .pull_en             (pull_en),
      .tx_err              (tx_err)
   );

   typedef struct {
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [15:0] word;
   } rx_vec_t;

   typedef struct {
      logic [15:0] word;
      logic [7:0]  e0;
      logic [7:0]  e1;
      int          stall;
   } tx_vec_t;

   int n_total = 0;
   int n_pass  = 0;

   logic [15:0] exp_q[$];
   int          n_pulses = 0;
   bit          mon_en   = 1'b1;
   logic        mv_prev  = 1'b0;
   int          hi_len   = 0;
   int          lo_len   = 0;
   bit          seen_fall = 1'b0;
   logic [15:0] prev_data = '0;
   logic [15:0] rise_data = '0;
   logic [15:0] exp_w;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Ingress strobe monitor: word value, setup lead, high width, low gap.
   always @(negedge clk) begin
      if (!rstb || !mon_en) begin
         mv_prev   = 1'b0;
         hi_len    = 0;
         lo_len    = 0;
         seen_fall = 1'b0;
      end else begin
         if (core_data_in_valid && !mv_prev) begin
            n_pulses++;
            if (seen_fall) check("rx_low_gap", (lo_len >= 2), 1);
            check("rx_word_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               exp_w = exp_q.pop_front();
               check("rx_word_setup", prev_data, exp_w);
               check("rx_word", core_data_in, exp_w);
            end
            rise_data = core_data_in;
            hi_len = 1;
         end else if (core_data_in_valid) begin
            hi_len++;
         end else if (mv_prev) begin
            check("rx_high_len", hi_len, 2);
            check("rx_word_stable", core_data_in, rise_data);
            lo_len    = 1;
            seen_fall = 1'b1;
         end else begin
            lo_len++;
         end
         mv_prev = core_data_in_valid;
      end
      prev_data = core_data_in;
   end

   task automatic send_byte(input logic [7:0] b);
      int guard;
      host_rx_byte  = b;
      host_rx_valid = 1'b1;
      guard = 0;
      while (!host_rx_ready && guard < 50) begin
         tick();
         guard++;
      end
      check("rx_ready_wait", host_rx_ready, 1);
      tick();
      host_rx_valid = 1'b0;
   endtask

   task automatic wait_tx_done();
      int guard;
      guard = 0;
      while (!core_tx_done && guard < 40) begin
         tick();
         guard++;
      end
      check("tx_done_wait", core_tx_done, 1);
   endtask

   task automatic egress_xfer(input logic [15:0] w, input logic [7:0] e0,
                              input logic [7:0] e1, input int stall);
      wait_tx_done();
      tick();
      check("tx_done_hold", core_tx_done, 1);
      core_data_out       = w;
      core_data_out_valid = 1'b1;
      tick();
      check("tx_done_fall", core_tx_done, 0);
      check("tx_b0_valid", host_tx_valid, 1);
      check("tx_b0_byte", host_tx_byte, e0);
      core_data_out_valid = 1'b0;
      host_tx_ready       = 1'b0;
      for (int i = 0; i < stall; i++) begin
         tick();
         check("tx_b0_stall_byte", host_tx_byte, e0);
         check("tx_b0_stall_valid", host_tx_valid, 1);
      end
      host_tx_ready = 1'b1;
      tick();
      check("tx_b1_valid", host_tx_valid, 1);
      check("tx_b1_byte", host_tx_byte, e1);
      tick();
      check("tx_done_valid_low", host_tx_valid, 0);
      host_tx_ready = 1'b0;
   endtask

   rx_vec_t rxv[4];
   tx_vec_t txv[3];

   initial begin
      int          idx;
      int          guard;
      int          cnt;
      int          p0;
      bit          hs;
      logic [7:0]  bq[$];

      rxv[0] = '{8'h34, 8'h12, 16'h1234};
      rxv[1] = '{8'h00, 8'h00, 16'h0000};
      rxv[2] = '{8'hFF, 8'hFF, 16'hFFFF};
      rxv[3] = '{8'hA5, 8'hA5, 16'hA5A5};
      txv[0] = '{16'hBEEF, 8'hEF, 8'hBE, 5};
      txv[1] = '{16'h0001, 8'h01, 8'h00, 0};
      txv[2] = '{16'h80FE, 8'hFE, 8'h80, 2};

      rstb                = 1'b0;
      host_rx_byte        = '0;
      host_rx_valid       = 1'b0;
      host_tx_ready       = 1'b0;
      core_data_out       = '0;
      core_data_out_valid = 1'b0;
      core_busy           = 1'b0;
      pull_en             = 1'b0;

      // Reset state, during and just after reset.
      repeat (3) tick();
      check("rst_rx_ready_in_reset", host_rx_ready, 0);
      check("rst_data_in", core_data_in, 16'h0000);
      rstb = 1'b1;
      #1;
      check("rel_rx_ready", host_rx_ready, 1);
      check("rel_data_in_valid", core_data_in_valid, 0);
      check("rel_tx_done", core_tx_done, 0);
      check("rel_tx_valid", host_tx_valid, 0);
      check("rel_tx_byte", host_tx_byte, 8'h00);
      check("rel_tx_err", tx_err, 0);
      tick();

      // Single word with exact handshake-to-strobe timing.
      exp_q.push_back(rxv[0].word);
      p0 = n_pulses;
      send_byte(rxv[0].b0);
      send_byte(rxv[0].b1);
      check("w1_n0_ready", host_rx_ready, 0);
      check("w1_n0_valid", core_data_in_valid, 0);
      tick();
      check("w1_n1_data", core_data_in, 16'h1234);
      check("w1_n1_valid", core_data_in_valid, 0);
      check("w1_n1_ready", host_rx_ready, 0);
      tick();
      check("w1_n2_valid", core_data_in_valid, 1);
      check("w1_n2_ready", host_rx_ready, 0);
      tick();
      check("w1_n3_valid", core_data_in_valid, 1);
      check("w1_n3_ready", host_rx_ready, 0);
      tick();
      check("w1_n4_valid", core_data_in_valid, 0);
      check("w1_n4_ready", host_rx_ready, 0);
      tick();
      check("w1_n5_valid", core_data_in_valid, 0);
      check("w1_n5_ready", host_rx_ready, 1);
      repeat (2) tick();
      check("w1_pulses", n_pulses - p0, 1);

      // Back-to-back words with host_rx_valid held high.
      for (int v = 1; v < 4; v++) begin
         bq.push_back(rxv[v].b0);
         bq.push_back(rxv[v].b1);
         exp_q.push_back(rxv[v].word);
      end
      p0 = n_pulses;
      idx = 0;
      guard = 0;
      host_rx_valid = 1'b1;
      host_rx_byte  = bq[0];
      while (idx < 6 && guard < 200) begin
         hs = host_rx_ready;
         tick();
         guard++;
         if (hs) begin
            idx++;
            if (idx < 6) host_rx_byte = bq[idx];
         end
      end
      host_rx_valid = 1'b0;
      check("b2b_bytes_taken", idx, 6);
      repeat (10) tick();
      check("b2b_pulses", n_pulses - p0, 3);
      check("b2b_queue_empty", exp_q.size(), 0);

      // Egress: table of captures with host backpressure.
      pull_en = 1'b1;
      for (int v = 0; v < 3; v++)
         egress_xfer(txv[v].word, txv[v].e0, txv[v].e1, txv[v].stall);

      // Timeout re-pulse while the core stays silent.
      pull_en = 1'b0;
      repeat (2) tick();
      check("idle_tx_done", core_tx_done, 0);
      pull_en = 1'b1;
      wait_tx_done();
      for (int r = 0; r < 2; r++) begin
         cnt = 0;
         while (core_tx_done && cnt < 40) begin
            cnt++;
            tick();
         end
         check("to_high_len", cnt, 16);
         check("to_gap_low", core_tx_done, 0);
         tick();
         check("to_gap_len", core_tx_done, 1);
      end
      egress_xfer(16'h1357, 8'h57, 8'h13, 0);

      // core_busy rising aborts an outstanding request.
      wait_tx_done();
      core_busy = 1'b1;
      tick();
      check("busy_abort", core_tx_done, 0);
      repeat (3) tick();
      check("busy_hold", core_tx_done, 0);
      core_busy = 1'b0;

      // Overrun edge during TX_B0, and pull_en dropped mid-serialization.
      check("err_before", tx_err, 0);
      wait_tx_done();
      core_data_out       = 16'hBEEF;
      core_data_out_valid = 1'b1;
      tick();
      check("ov_b0_byte", host_tx_byte, 8'hEF);
      core_data_out_valid = 1'b0;
      host_tx_ready       = 1'b0;
      tick();
      core_data_out       = 16'h0BAD;
      core_data_out_valid = 1'b1;
      tick();
      check("ov_err_set", tx_err, 1);
      check("ov_b0_byte_kept", host_tx_byte, 8'hEF);
      check("ov_b0_valid_kept", host_tx_valid, 1);
      core_data_out_valid = 1'b0;
      pull_en             = 1'b0;
      host_tx_ready       = 1'b1;
      tick();
      check("ov_b1_byte", host_tx_byte, 8'hBE);
      check("ov_b1_valid", host_tx_valid, 1);
      tick();
      host_tx_ready = 1'b0;
      check("ov_done_valid", host_tx_valid, 0);
      repeat (3) tick();
      check("ov_err_sticky", tx_err, 1);
      check("ov_no_req", core_tx_done, 0);

      // Reset in the middle of DRIVE_HI, then a discarded partial word.
      mon_en = 1'b0;
      send_byte(8'h11);
      send_byte(8'h22);
      guard = 0;
      while (!core_data_in_valid && guard < 10) begin
         tick();
         guard++;
      end
      check("rst_reach_drive_hi", core_data_in_valid, 1);
      rstb = 1'b0;
      #1;
      check("mid_rst_valid", core_data_in_valid, 0);
      check("mid_rst_data", core_data_in, 16'h0000);
      check("mid_rst_ready", host_rx_ready, 0);
      check("mid_rst_tx_err", tx_err, 0);
      check("mid_rst_tx_done", core_tx_done, 0);
      check("mid_rst_tx_valid", host_tx_valid, 0);
      tick();
      rstb = 1'b1;
      #1;
      check("rel2_ready", host_rx_ready, 1);
      send_byte(8'hAA);
      rstb = 1'b0;
      tick();
      rstb = 1'b1;
      tick();
      mon_en = 1'b1;
      exp_q.push_back(16'h5678);
      p0 = n_pulses;
      send_byte(8'h78);
      send_byte(8'h56);
      repeat (8) tick();
      check("after_rst_pulses", n_pulses - p0, 1);
      check("after_rst_queue", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
